// File: rtl/shift_reg_n.sv
// Multi-mode shift/rotate register with a small IDLE/RUN sequencer.
// One accepted start runs max(amt,1) steps of mode M, then pulses done.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   start request one operation (looked at only in IDLE)
//   M     operation select, captured on the accepting edge
//   amt   step count, captured on the accepting edge (0 acts as 1)
//   D     parallel load data, used on the accepting edge only
//   SI    serial input, sampled on every step edge
//   Q     register contents
//   SO_L  Q[WIDTH-1]
//   SO_R  Q[0]
//   busy  high while a multi-step operation is still running
//   done  one-cycle pulse after the last step
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       M,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO_L,
    output logic             SO_R,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AMT_W-1:0] AMT_ZERO = '0;
    localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [2:0]       m_r;
    logic [2:0]       m_n;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] rem_n;
    logic             done_r;
    logic             done_n;
    logic             single;

    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             si
    );
        logic [WIDTH-1:0] r;
        r = cur;
        unique case (mode)
            3'b000: r = cur;
            3'b001: r = din;
            3'b010: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b011: r = {si, cur[WIDTH-1:1]};
            3'b100: r = {cur[WIDTH-2:0], si};
            3'b101: r = {cur[0], cur[WIDTH-1:1]};
            3'b110: r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'b111: r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // hold, load and clear never repeat, whatever amt says
    assign single = (M == 3'b000) || (M == 3'b001) || (M == 3'b111);

    always_comb begin
        state_n = state;
        q_n     = q;
        m_n     = m_r;
        rem_n   = rem;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    q_n = step_fn(M, q, D, SI);
                    m_n = M;
                    if (single || amt == AMT_ZERO) begin
                        rem_n = AMT_ZERO;
                    end else begin
                        rem_n = amt - AMT_ONE;
                    end
                    if (rem_n != AMT_ZERO) begin
                        state_n = RUN;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                q_n   = step_fn(m_r, q, D, SI);
                rem_n = rem - AMT_ONE;
                if (rem == AMT_ONE) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            m_r    <= 3'b000;
            rem    <= AMT_ZERO;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            m_r    <= m_n;
            rem    <= rem_n;
            done_r <= done_n;
        end
    end

    assign Q    = q;
    assign SO_L = q[WIDTH-1];
    assign SO_R = q[0];
    assign busy = (state == RUN);
    assign done = done_r;

endmodule

// File: tb/tb_shift_reg_n.sv
// Bench for shift_reg_n (WIDTH=8): directed vectors, an operation-level
// reference model, and a per-cycle comparison against that model.
module tb_shift_reg_n;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    M;
    logic [AW-1:0] amt;
    logic [W-1:0]  D;
    logic          SI;
    logic [W-1:0]  Q;
    logic          SO_L;
    logic          SO_R;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .M     (M),
        .amt   (amt),
        .D     (D),
        .SI    (SI),
        .Q     (Q),
        .SO_L  (SO_L),
        .SO_R  (SO_R),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation is "mode applied N times".
    bit         started = 0;
    int         mq;
    int         left;
    int         mmode;
    bit         mbusy;
    bit         mdone;

    function automatic int apply(input int mode, input int v, input int d,
                                 input int si);
        int mask;
        mask = (1 << W) - 1;
        case (mode)
            0: return v;
            1: return d & mask;
            2: return ((v << 1) | (v >> (W - 1))) & mask;
            3: return (v >> 1) | (si << (W - 1));
            4: return ((v << 1) | si) & mask;
            5: return (v >> 1) | ((v & 1) << (W - 1));
            6: return (v >> 1) | (v & (1 << (W - 1)));
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            started = 1;
            mq      = 0;
            left    = 0;
            mbusy   = 0;
            mdone   = 0;
        end else if (started) begin
            if (left > 0) begin
                mq    = apply(mmode, mq, 0, int'(SI));
                left  = left - 1;
                mbusy = (left > 0);
                mdone = (left == 0);
            end else if (start) begin
                int n;
                mmode = int'(M);
                mq    = apply(mmode, mq, int'(D), int'(SI));
                n     = (amt == 0) ? 1 : int'(amt);
                if (mmode == 0 || mmode == 1 || mmode == 7) n = 1;
                left  = n - 1;
                mbusy = (left > 0);
                mdone = (left == 0);
            end else begin
                mdone = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started && rst === 1'b0) begin
            chk("q_model", 32'(Q), 32'(mq));
            chk("sol_model", 32'(SO_L), 32'((mq >> (W - 1)) & 1));
            chk("sor_model", 32'(SO_R), 32'(mq & 1));
            chk("busy_model", 32'(busy), 32'(mbusy));
            chk("done_model", 32'(done), 32'(mdone));
            chk("busy_done_excl", 32'(busy & done), 32'd0);
        end
    end

    // Called just after a negedge; returns at the negedge after the
    // accepting edge.
    task automatic go(input logic [2:0] m, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic si);
        start = 1'b1;
        M     = m;
        amt   = a;
        D     = d;
        SI    = si;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (mbusy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic op(input string nm, input logic [2:0] m,
                      input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic si, input logic [W-1:0] exp);
        go(m, a, d, si);
        wait_idle();
        chk({nm, "_q"}, 32'(Q), 32'(exp));
        chk({nm, "_model"}, 32'(mq), 32'(exp));
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        M     = 3'b000;
        amt   = '0;
        D     = '0;
        SI    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_q", 32'(Q), 32'h00);
        chk("rst_sol", 32'(SO_L), 32'd0);
        chk("rst_sor", 32'(SO_R), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);

        op("load_b5", 3'b001, 4'd0, 8'hB5, 1'b0, 8'hB5);
        @(negedge clk);
        chk("load_done_1cyc", 32'(done), 32'd0);

        // rotate left 3 with start/M/D wiggled while busy
        start = 1'b1;
        M     = 3'b010;
        amt   = 4'd3;
        @(negedge clk);
        chk("rotl_busy1", 32'(busy), 32'd1);
        M = 3'b111;
        D = 8'h00;
        @(negedge clk);
        chk("rotl_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("rotl_q", 32'(Q), 32'hAD);
        chk("rotl_done", 32'(done), 32'd1);
        chk("rotl_busy3", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rotl_idle", 32'(Q), 32'hAD);

        op("load_81", 3'b001, 4'd0, 8'h81, 1'b0, 8'h81);
        op("asr2", 3'b110, 4'd2, 8'h00, 1'b0, 8'hE0);
        op("ror1_b2b", 3'b101, 4'd1, 8'h00, 1'b0, 8'h70);
        op("clear", 3'b111, 4'd5, 8'hFF, 1'b0, 8'h00);
        op("shr_si1", 3'b011, 4'd8, 8'h00, 1'b1, 8'hFF);
        @(negedge clk);
        op("clear2", 3'b111, 4'd0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);

        // shift right 8 with SI 1,0,1,0... and start held high
        start = 1'b1;
        M     = 3'b011;
        amt   = 4'd8;
        SI    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            SI = (k % 2 == 0);
        end
        @(negedge clk);
        start = 1'b0;
        chk("shr_alt_q", 32'(Q), 32'h55);
        chk("shr_alt_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("shr_alt_noreacc", 32'(busy), 32'd0);
        chk("shr_alt_hold", 32'(Q), 32'h55);

        // reset in the middle of a shift-left run
        op("load_0f", 3'b001, 4'd0, 8'h0F, 1'b0, 8'h0F);
        go(3'b100, 4'd6, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_q", 32'(Q), 32'h00);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_nodone", 32'(done), 32'd0);

        op("load_3c", 3'b001, 4'd0, 8'h3C, 1'b0, 8'h3C);
        op("shl2_b2b", 3'b100, 4'd2, 8'h00, 1'b1, 8'hF3);
        op("load_81b", 3'b001, 4'd0, 8'h81, 1'b0, 8'h81);
        op("rotl9", 3'b010, 4'd9, 8'h00, 1'b0, 8'h03);
        op("load_80", 3'b001, 4'd0, 8'h80, 1'b0, 8'h80);
        op("asr12", 3'b110, 4'd12, 8'h00, 1'b0, 8'hFF);
        op("hold", 3'b000, 4'd7, 8'h12, 1'b1, 8'hFF);
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH)+1, width of the step-count input.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; all state updates on rising edge of clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to execute one operation; sampled only in IDLE.
REQ-006 SHALL have port M  input  3  operation select, latched at start.
REQ-007 SHALL have port amt  input  AMT_W  step count, latched at start; 0 treated as 1.
REQ-008 SHALL have port D  input  WIDTH  parallel load data, sampled on the accepting edge only.
REQ-009 SHALL have port SI  input  1  serial input, sampled live on every step edge.
REQ-010 SHALL have port Q  output  WIDTH  register contents.
REQ-011 SHALL have port SO_L  output  1  Q[WIDTH-1].
REQ-012 SHALL have port SO_R  output  1  Q[0].
REQ-013 SHALL have port busy  output  1  high while multi-step operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL decode M: 000 hold; 001 load D; 010 rotate left; 011 shift right, SI into MSB; 100 shift left, SI into LSB; 101 rotate right; 110 arithmetic shift right (MSB replicated); 111 clear to 0.
REQ-016 SHALL implement FSM states IDLE and RUN; reset state IDLE.
REQ-017 IDLE, start=0: Q held, busy=0, done=0 next cycle.
REQ-018 IDLE, start=1: SHALL perform step 1 of M on that edge and latch M and remaining = max(amt,1)-1.
REQ-019 Modes 000, 001, 111 SHALL always be single-step regardless of amt.
REQ-020 remaining=0 after accepting edge: stay IDLE, done=1 for the following cycle, busy stays 0.
REQ-021 remaining>0 after accepting edge: enter RUN, busy=1.
REQ-022 RUN: each edge SHALL perform one step of latched M and decrement remaining; the edge where remaining goes 1->0 SHALL return to IDLE, drive busy=0 and done=1 for the following cycle.
REQ-023 Total steps for shift/rotate modes SHALL equal max(amt,1); amt > WIDTH permitted, shifts beyond WIDTH fill entirely with SI/sign, rotates wrap modulo WIDTH naturally.
REQ-024 start, M, amt, D SHALL be ignored while busy=1; no queuing.
REQ-025 start asserted in the cycle done=1 (FSM in IDLE) SHALL be accepted normally (back-to-back operations).
REQ-026 busy and done SHALL never be high in the same cycle.
REQ-027 SO_L and SO_R SHALL be combinational from Q, zero added latency.

Reset
REQ-028 rst=1 on a rising edge SHALL force Q=0, state IDLE, remaining=0, busy=0, done=0, overriding start and any in-progress operation.
REQ-029 rst mid-RUN SHALL abort without a done pulse.
REQ-030 Before first rst, outputs are undefined; bench SHALL apply rst first.

Verification (WIDTH=8)
REQ-031 rst=1 one edge -> Q=0x00, SO_L=0, SO_R=0, busy=0, done=0.
REQ-032 start, M=001, D=0xB5, amt=0 -> after 1 edge Q=0xB5, done=1 one cycle, busy=0 throughout.
REQ-033 From Q=0xB5: start, M=010, amt=3 -> busy=1 for 2 cycles, after 3rd edge Q=0xAD, done=1 one cycle; D/M changes during busy have no effect.
REQ-034 From Q=0x81: start, M=110, amt=2 -> Q=0xE0 with done; then start, M=101, amt=1 -> Q=0x70.
REQ-035 From Q=0x00: start, M=011, SI=1, amt=8 -> Q=0xFF after 8 edges; repeat with SI toggling 1,0 per cycle -> Q=0x55; start held high during busy not re-accepted.
REQ-036 From Q=0x0F: start, M=100, SI=0, amt=6, rst=1 after 3rd edge -> Q=0x00, busy=0, no done pulse; start on done cycle of a following op accepted back-to-back.
